// File: rtl/mem_line_responder_if.sv
// Request/response bus between the cache miss handler (master) and the
// line responder (slave).
interface mem_line_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic [15:0] rsp_addr;
  logic        rsp_last;
  logic        wr_ack;
  logic        busy;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_data, rsp_addr, rsp_last, wr_ack, busy
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_data, rsp_addr, rsp_last, wr_ack, busy
  );
endinterface

// File: rtl/mem_line_responder.sv
// Main-memory responder: fixed-latency line-fill bursts and single-word writes.
// Define CRITICAL_WORD_FIRST_EN to start each burst at the requested word.
module mem_line_responder #(
  parameter int DEPTH_WORDS = 32768,
  parameter int LATENCY     = 4,
  parameter int LINE_WORDS  = 8
) (
  input logic                 clk,
  input logic                 rst,
  mem_line_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int LW = $clog2(LINE_WORDS);
  localparam int HW = 15 - LW;
  localparam logic [3:0]    WAIT_LAST = 4'(LATENCY - 2);
  localparam logic [LW-1:0] LAST_BEAT = LW'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, WAIT_RD, BURST, WAIT_WR} state_t;

  state_t        state;
  logic [15:0]   mem [DEPTH_WORDS];
  logic [3:0]    cnt;
  logic [LW-1:0] beat;
  logic [LW-1:0] start_off;
  logic [HW-1:0] line_hi;

  logic          req_ready_q, busy_q, rsp_valid_q, rsp_last_q, wr_ack_q;
  logic [15:0]   rsp_data_q, rsp_addr_q;

  logic          accept, emit;
  logic [LW-1:0] cur_off;
  logic [15:0]   cur_addr;
  logic [AW-1:0] cur_idx, wr_idx;
  logic          unused_addr_bit;

  assign accept          = bus.req_valid & req_ready_q;
  assign cur_off         = start_off + beat;   // wraps inside the line
  assign cur_addr        = {line_hi, cur_off, 1'b0};
  assign cur_idx         = cur_addr[AW:1];
  assign wr_idx          = bus.req_addr[AW:1];
  assign unused_addr_bit = bus.req_addr[0];

  // A beat is produced on the last wait cycle and on every non-final burst cycle.
  assign emit = ((state == WAIT_RD) && (cnt == WAIT_LAST)) ||
                ((state == BURST) && !rsp_last_q);

  // Storage is not reset; a write commits on its accept edge.
  always_ff @(posedge clk) begin
    if (accept && bus.req_wr && !rst)
      mem[wr_idx] <= bus.req_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      beat        <= '0;
      start_off   <= '0;
      line_hi     <= '0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      wr_ack_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_addr_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            cnt         <= '0;
            beat        <= '0;
            if (bus.req_wr) begin
              state <= WAIT_WR;
            end else begin
              state   <= WAIT_RD;
              line_hi <= bus.req_addr[15:LW+1];
`ifdef CRITICAL_WORD_FIRST_EN
              start_off <= bus.req_addr[LW:1];
`else
              start_off <= '0;
`endif
            end
          end
        end
        WAIT_RD: begin
          if (cnt == WAIT_LAST) state <= BURST;
          else                  cnt   <= cnt + 4'd1;
        end
        BURST: begin
          if (rsp_last_q) begin
            state       <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        WAIT_WR: begin
          if (wr_ack_q) begin
            state       <= IDLE;
            wr_ack_q    <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end else if (cnt == WAIT_LAST) begin
            wr_ack_q <= 1'b1;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
      endcase

      if (emit) begin
        rsp_valid_q <= 1'b1;
        rsp_data_q  <= mem[cur_idx];
        rsp_addr_q  <= cur_addr;
        rsp_last_q  <= (beat == LAST_BEAT);
        beat        <= beat + 1'b1;
      end
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.busy      = busy_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_last  = rsp_last_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_addr  = rsp_addr_q;
  assign bus.wr_ack    = wr_ack_q;
endmodule

// File: tb/tb_mem_line_responder.sv
// Directed bench for mem_line_responder: one 1024-word LATENCY=4 instance
// and one LATENCY=2 instance for the short-latency timing check.
module tb_mem_line_responder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_line_responder_if b1();
  mem_line_responder_if b2();

  mem_line_responder #(.DEPTH_WORDS(1024), .LATENCY(4), .LINE_WORDS(8)) dut (
    .clk(clk), .rst(rst), .bus(b1));
  mem_line_responder #(.DEPTH_WORDS(64), .LATENCY(2), .LINE_WORDS(8)) dut2 (
    .clk(clk), .rst(rst), .bus(b2));

  int passed = 0;
  int total  = 0;
  logic [15:0] la[8], lb[8], lc[8];

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    int n;
    chk("wr.ready_pre", b1.req_ready, 1'b1);
    b1.req_valid = 1'b1; b1.req_wr = 1'b1; b1.req_addr = a; b1.req_wdata = d;
    tick();
    b1.req_valid = 1'b0; b1.req_wr = 1'b0;
    n = 1;
    while (!b1.wr_ack && n < 20) begin tick(); n++; end
    chk("wr.ack_latency", 16'(n), 16'd4);
    tick();
    chk("wr.ready_post", b1.req_ready, 1'b1);
  endtask

  // Accept a read, then check every cycle T+1..T+12 against the line image.
  task automatic rd_check(input logic [15:0] a, input logic [15:0] line[8], input string tag);
    int st, o;
    st = 0;
`ifdef CRITICAL_WORD_FIRST_EN
    st = int'(a[3:1]);
`endif
    chk({tag, ".ready_pre"}, b1.req_ready, 1'b1);
    b1.req_valid = 1'b1; b1.req_wr = 1'b0; b1.req_addr = a;
    tick();
    b1.req_valid = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      if (n >= 4 && n <= 11) begin
        o = (st + n - 4) % 8;
        chk({tag, ".valid"}, b1.rsp_valid, 1'b1);
        chk({tag, ".data"},  b1.rsp_data, line[o]);
        chk({tag, ".addr"},  b1.rsp_addr, {a[15:4], 3'(o), 1'b0});
        chk({tag, ".last"},  b1.rsp_last, 1'(n == 11));
      end else begin
        chk({tag, ".idle_valid"}, b1.rsp_valid, 1'b0);
      end
      chk({tag, ".ready"}, b1.req_ready, 1'(n == 12));
      if (n < 12) tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, beats;
    b1.req_valid = 1'b0; b1.req_wr = 1'b0; b1.req_addr = '0; b1.req_wdata = '0;
    b2.req_valid = 1'b0; b2.req_wr = 1'b0; b2.req_addr = '0; b2.req_wdata = '0;
    for (int i = 0; i < 8; i++) begin
      la[i] = 16'hA000 + 16'(i);
      lb[i] = 16'hB000 + 16'(i);
      lc[i] = 16'hC000 + 16'(i);
    end

    #1 rst = 1'b1;
    #1;
    chk("rst.ready",     b1.req_ready, 1'b1);
    chk("rst.valid",     b1.rsp_valid, 1'b0);
    chk("rst.last",      b1.rsp_last,  1'b0);
    chk("rst.wr_ack",    b1.wr_ack,    1'b0);
    chk("rst.busy",      b1.busy,      1'b0);
    chk("rst.rsp_data",  b1.rsp_data,  16'h0000);
    chk("rst.rsp_addr",  b1.rsp_addr,  16'h0000);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Preload three lines: words 0..7, 8..15, 16..23.
    for (int i = 0; i < 8; i++) wr(16'h0010 + 16'(2*i), la[i]);
    for (int i = 0; i < 8; i++) wr(16'h0020 + 16'(2*i), lb[i]);
    for (int i = 0; i < 8; i++) wr(16'h0000 + 16'(2*i), lc[i]);

    rd_check(16'h0014, la, "basic");

    wr(16'h0022, 16'hBEEF);
    lb[1] = 16'hBEEF;
    rd_check(16'h0020, lb, "raw");

    // Byte 0x0800 is word 1024, which aliases word 0 in a 1024-word memory.
    wr(16'h0800, 16'h1234);
    lc[0] = 16'h1234;
    rd_check(16'h0000, lc, "wrap");

    // Reset in the middle of a burst.
    b1.req_valid = 1'b1; b1.req_wr = 1'b0; b1.req_addr = 16'h0010;
    tick();
    b1.req_valid = 1'b0;
    beats = 0; n = 0;
    while (beats < 3 && n < 20) begin
      if (b1.rsp_valid) beats++;
      if (beats < 3) begin tick(); n++; end
    end
    chk("rst_mid.beats_seen", 16'(beats), 16'd3);
    rst = 1'b1;
    #1;
    chk("rst_mid.valid", b1.rsp_valid, 1'b0);
    chk("rst_mid.ready", b1.req_ready, 1'b1);
    chk("rst_mid.busy",  b1.busy,      1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick();
    chk("rst_mid.still_idle", b1.rsp_valid, 1'b0);
    rd_check(16'h0010, la, "post_rst");

    // Back-pressure: req_valid stays high with changing addresses.
    b1.req_valid = 1'b1; b1.req_wr = 1'b0; b1.req_addr = 16'h0010;
    tick();
    n = 1;
    while (!(b1.rsp_valid && b1.rsp_last) && n < 20) begin
      b1.req_addr = 16'h0100 + 16'(n * 16);
      tick(); n++;
    end
    chk("bp.last_cycle", 16'(n), 16'd11);
    chk("bp.last_addr",  b1.rsp_addr, 16'h001E);
    b1.req_addr = 16'h0020;
    tick();
    chk("bp.ready_after_last", b1.req_ready, 1'b1);
    chk("bp.valid_after_last", b1.rsp_valid, 1'b0);
    tick();
    b1.req_valid = 1'b0;
    chk("bp.accepted_ready", b1.req_ready, 1'b0);
    chk("bp.accepted_busy",  b1.busy,      1'b1);
    tick(); tick(); tick();
    chk("bp.beat0_valid", b1.rsp_valid, 1'b1);
    chk("bp.beat0_addr",  b1.rsp_addr,  16'h0020);
    chk("bp.beat0_data",  b1.rsp_data,  16'hB000);
    tick();
    chk("bp.beat1_data",  b1.rsp_data,  16'hBEEF);
    n = 0;
    while (!b1.req_ready && n < 20) begin tick(); n++; end
    chk("bp.drain", b1.req_ready, 1'b1);

    // LATENCY=2 instance: beats on T+2..T+9.
    b2.req_valid = 1'b1; b2.req_wr = 1'b0; b2.req_addr = 16'h0030;
    tick();
    b2.req_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      chk("lat2.valid", b2.rsp_valid, 1'(k >= 2 && k <= 9));
      chk("lat2.last",  b2.rsp_last,  1'(k == 9));
      if (k == 2) chk("lat2.first_addr", b2.rsp_addr, 16'h0030);
      if (k < 10) tick();
    end
    chk("lat2.ready", b2.req_ready, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
